// File: rtl/chopper_timers_if.sv
// chopper_timers_if: config, start requests and timer readback between control stage and chopper timers
interface chopper_timers_if;
    logic       enable;
    logic       offtimer_en0;
    logic       offtimer_en1;
    logic [3:0] config_prescale;
    logic [9:0] config_offtime;
    logic [7:0] config_blanktime;
    logic [7:0] config_minon;
    logic [9:0] off_timer0;
    logic [9:0] off_timer1;
    logic [7:0] blank_timer0;
    logic [7:0] blank_timer1;
    logic [7:0] minimum_on_timer0;
    logic [7:0] minimum_on_timer1;
    logic       off_active0;
    logic       off_active1;
    modport master (
        output enable, offtimer_en0, offtimer_en1, config_prescale, config_offtime,
               config_blanktime, config_minon,
        input  off_timer0, off_timer1, blank_timer0, blank_timer1,
               minimum_on_timer0, minimum_on_timer1, off_active0, off_active1
    );
    modport slave (
        input  enable, offtimer_en0, offtimer_en1, config_prescale, config_offtime,
               config_blanktime, config_minon,
        output off_timer0, off_timer1, blank_timer0, blank_timer1,
               minimum_on_timer0, minimum_on_timer1, off_active0, off_active1
    );
endinterface

// File: rtl/chopper_timers.sv
// chopper_timers: per-bridge blank/off/min-on timers with a shared tick prescaler
module chopper_timers (
    input logic            clk,
    input logic            reset,
    chopper_timers_if.slave tmr
);
    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_ON, S_OFF} state_t;
    logic [3:0] r_pcnt;
    logic       w_tick;
    assign w_tick = r_pcnt >= tmr.config_prescale;
    always_ff @(posedge clk or posedge reset)
        if (reset) r_pcnt <= '0;
        else       r_pcnt <= w_tick ? 4'd0 : r_pcnt + 4'd1;
    for (genvar c = 0; c < 2; c++) begin : g_ch
        state_t     r_state, w_state;
        logic [9:0] r_off, w_off;
        logic [7:0] r_blank, w_blank, r_minon, w_minon;
        logic       r_act, w_req;
        assign w_req = (c == 0) ? tmr.offtimer_en0 : tmr.offtimer_en1;
        always_ff @(posedge clk or posedge reset)
            if (reset) begin
                r_state <= S_IDLE;
                r_off   <= '0;
                r_blank <= '0;
                r_minon <= '0;
                r_act   <= 1'b0;
            end else begin
                r_state <= w_state;
                r_off   <= w_off;
                r_blank <= w_blank;
                r_minon <= w_minon;
                r_act   <= w_state == S_OFF;
            end
        // loads are written after the decrement defaults so they win; enable low overrides all
        always_comb begin
            w_state = r_state;
            w_off   = r_off;
            w_blank = r_blank;
            w_minon = (w_tick && r_minon != 8'd0) ? r_minon - 8'd1 : r_minon;
            case (r_state)
                S_IDLE: begin
                    w_blank = tmr.config_blanktime;
                    w_minon = tmr.config_minon;
                    w_state = tmr.config_blanktime == 8'd0 ? S_ON : S_BLANK;
                end
                S_BLANK: if (w_tick && r_blank != 8'd0) begin
                    w_blank = r_blank - 8'd1;
                    if (r_blank == 8'd1) w_state = S_ON;
                end
                S_ON: if (w_req && tmr.config_offtime != 10'd0) begin
                    w_off   = tmr.config_offtime;
                    w_state = S_OFF;
                end
                S_OFF: if (w_tick && r_off != 10'd0) begin
                    w_off = r_off - 10'd1;
                    if (r_off == 10'd1) begin
                        w_blank = tmr.config_blanktime;
                        w_minon = tmr.config_minon;
                        w_state = tmr.config_blanktime == 8'd0 ? S_ON : S_BLANK;
                    end
                end
            endcase
            if (!tmr.enable) begin
                w_state = S_IDLE;
                w_off   = '0;
                w_blank = '0;
                w_minon = '0;
            end
        end
    end
    assign tmr.off_timer0        = g_ch[0].r_off;
    assign tmr.off_timer1        = g_ch[1].r_off;
    assign tmr.blank_timer0      = g_ch[0].r_blank;
    assign tmr.blank_timer1      = g_ch[1].r_blank;
    assign tmr.minimum_on_timer0 = g_ch[0].r_minon;
    assign tmr.minimum_on_timer1 = g_ch[1].r_minon;
    assign tmr.off_active0       = g_ch[0].r_act;
    assign tmr.off_active1       = g_ch[1].r_act;
endmodule

// File: tb/tb_chopper_timers.sv
// tb_chopper_timers: directed vectors with hand-computed expectations for chopper_timers
module tb_chopper_timers;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    int   n_act;
    chopper_timers_if bus();
    chopper_timers dut (.clk(clk), .reset(reset), .tmr(bus.slave));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask
    initial begin
        bus.enable = 1'b0;
        bus.offtimer_en0 = 1'b0;
        bus.offtimer_en1 = 1'b0;
        bus.config_prescale = 4'd0;
        bus.config_offtime = 10'd10;
        bus.config_blanktime = 8'd5;
        bus.config_minon = 8'd3;
        step(2);
        chk("rst_off0", bus.off_timer0, 0);
        chk("rst_blank0", bus.blank_timer0, 0);
        chk("rst_minon1", bus.minimum_on_timer1, 0);
        chk("rst_act0", bus.off_active0, 0);
        reset = 1'b0;
        bus.enable = 1'b1;
        step();
        chk("en_blank0", bus.blank_timer0, 5);
        chk("en_minon0", bus.minimum_on_timer0, 3);
        chk("en_blank1", bus.blank_timer1, 5);
        bus.offtimer_en0 = 1'b1;
        step();
        bus.offtimer_en0 = 1'b0;
        chk("blank_ign_act", bus.off_active0, 0);
        chk("blank_ign_off", bus.off_timer0, 0);
        chk("blank_dec", bus.blank_timer0, 4);
        step(2);
        chk("minon_zero", bus.minimum_on_timer0, 0);
        chk("blank_2", bus.blank_timer0, 2);
        step(2);
        chk("blank_zero", bus.blank_timer0, 0);
        bus.offtimer_en0 = 1'b1;
        step();
        bus.offtimer_en0 = 1'b0;
        chk("off_load", bus.off_timer0, 10);
        chk("off_act", bus.off_active0, 1);
        n_act = 1;
        for (int k = 1; k <= 9; k++) begin
            bus.offtimer_en0 = (k == 5);
            step();
            chk("off_count", bus.off_timer0, 10 - k);
            n_act += bus.off_active0;
        end
        bus.offtimer_en0 = 1'b0;
        step();
        chk("off_exit_off", bus.off_timer0, 0);
        chk("off_exit_blank", bus.blank_timer0, 5);
        chk("off_exit_minon", bus.minimum_on_timer0, 3);
        chk("off_exit_act", bus.off_active0, 0);
        chk("off_act_len", n_act, 10);
        chk("ch1_quiet", bus.off_active1, 0);
        step(5);
        chk("reon_blank", bus.blank_timer0, 0);
        bus.config_offtime = 10'd0;
        bus.offtimer_en0 = 1'b1;
        step();
        bus.offtimer_en0 = 1'b0;
        chk("zero_off_act", bus.off_active0, 0);
        chk("zero_off_val", bus.off_timer0, 0);
        bus.config_prescale = 4'd3;
        bus.config_offtime = 10'd4;
        bus.offtimer_en0 = 1'b1;
        n_act = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            bus.offtimer_en0 = 1'b0;
            if (i == 3) chk("ps_hold", bus.off_timer0, 4);
            if (i == 4) chk("ps_tick", bus.off_timer0, 3);
            if (i == 8) chk("ps_tick2", bus.off_timer0, 2);
            n_act += bus.off_active0;
        end
        chk("ps_off_len", n_act, 15);
        chk("ps_blank", bus.blank_timer0, 4);
        bus.config_prescale = 4'd0;
        step(4);
        chk("ps_reon", bus.blank_timer0, 0);
        bus.config_offtime = 10'd10;
        bus.offtimer_en0 = 1'b1;
        step();
        bus.offtimer_en0 = 1'b0;
        step(4);
        chk("drop_pre", bus.off_timer0, 6);
        bus.enable = 1'b0;
        bus.offtimer_en0 = 1'b1;
        bus.offtimer_en1 = 1'b1;
        step();
        bus.offtimer_en0 = 1'b0;
        bus.offtimer_en1 = 1'b0;
        chk("drop_off0", bus.off_timer0, 0);
        chk("drop_blank0", bus.blank_timer0, 0);
        chk("drop_minon0", bus.minimum_on_timer0, 0);
        chk("drop_act0", bus.off_active0, 0);
        chk("drop_act1", bus.off_active1, 0);
        chk("drop_off1", bus.off_timer1, 0);
        bus.enable = 1'b1;
        step();
        chk("reen_blank0", bus.blank_timer0, 5);
        chk("reen_minon0", bus.minimum_on_timer0, 3);
        chk("reen_blank1", bus.blank_timer1, 5);
        bus.enable = 1'b0;
        step();
        bus.config_blanktime = 8'd2;
        bus.config_minon = 8'd9;
        bus.enable = 1'b1;
        step();
        chk("mo_load", bus.minimum_on_timer0, 9);
        step(2);
        chk("mo_on_minon", bus.minimum_on_timer0, 7);
        chk("mo_on_blank", bus.blank_timer0, 0);
        bus.offtimer_en0 = 1'b1;
        step();
        bus.offtimer_en0 = 1'b0;
        chk("mo_off0", bus.off_timer0, 10);
        chk("mo_minon0", bus.minimum_on_timer0, 6);
        chk("mo_act1_idle", bus.off_active1, 0);
        bus.config_offtime = 10'd7;
        bus.offtimer_en1 = 1'b1;
        step();
        bus.offtimer_en1 = 1'b0;
        chk("mo_off0_b", bus.off_timer0, 9);
        chk("mo_off1", bus.off_timer1, 7);
        chk("mo_act1", bus.off_active1, 1);
        chk("mo_minon1", bus.minimum_on_timer1, 5);
        step();
        chk("mo_off0_c", bus.off_timer0, 8);
        chk("mo_off1_c", bus.off_timer1, 6);
        chk("mo_minon0_c", bus.minimum_on_timer0, 4);
        #2 reset = 1'b1;
        #1;
        chk("arst_off0", bus.off_timer0, 0);
        chk("arst_act1", bus.off_active1, 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
